// File: rtl/sevenseg_scan_decoder_pkg.sv
// Shared display definitions: segment codes (common with the display driver),
// digit index type, scan-decoder FSM states and the mm:ss -> seconds helper.
package sevenseg_scan_decoder_pkg;

  // Active-low segment codes on seg[6:0] (g..a); a 0 bit lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALE   = 2'd2
  } scan_state_t;

  // Packed BCD frame {d3,d2,d1,d0} interpreted as mm:ss, returned in seconds.
  // Digits above 5 in the seconds-tens place are taken at face value.
  function automatic logic [12:0] frame_to_seconds(input logic [15:0] d);
    logic [12:0] mins;
    logic [12:0] secs;
    mins = 13'(d[15:12]) * 13'd10 + 13'(d[11:8]);
    secs = 13'(d[7:4]) * 13'd10 + 13'(d[3:0]);
    return mins * 13'd60 + secs;
  endfunction

endpackage

// File: rtl/sevenseg_scan_decoder_seg7_to_bcd.sv
// Combinational seven-segment to BCD decoder. An all-off pattern is reported
// as a valid blank digit (bcd = 0); any unknown pattern clears valid.
module seg7_to_bcd
  import sevenseg_scan_decoder_pkg::*;
(
  input  logic [6:0] code,
  output logic       valid,
  output logic       blank,
  output logic [3:0] bcd
);

  // Table lookup of the active-low segment pattern.
  always_comb begin
    valid = 1'b1;
    blank = 1'b0;
    bcd   = 4'd0;
    case (code)
      SEG_0:     bcd = 4'd0;
      SEG_1:     bcd = 4'd1;
      SEG_2:     bcd = 4'd2;
      SEG_3:     bcd = 4'd3;
      SEG_4:     bcd = 4'd4;
      SEG_5:     bcd = 4'd5;
      SEG_6:     bcd = 4'd6;
      SEG_7:     bcd = 4'd7;
      SEG_8:     bcd = 4'd8;
      SEG_9:     bcd = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// Display scan monitor: synchronizes the multiplexed an/seg bus, waits for
// each digit pattern to settle, decodes it, assembles complete 4-digit frames
// and reports the shown mm:ss value in seconds.
//
//   state   | meaning
//   IDLE    | after reset, no digit staged yet
//   COLLECT | staging digits; a frame completes once all four are seen
//   STALE   | no digit accepted for TIMEOUT_CYCLES; waiting for scan to resume
module sevenseg_scan_decoder
  import sevenseg_scan_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        segment_clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  blank,
  output logic        frame_done,
  output logic [12:0] value_sec,
  output logic        value_strobe,
  output logic        stale,
  output logic        bad_pattern,
  output logic        an_error
);

  localparam logic [3:0]  STABLE_L  = 4'(STABLE_CYCLES);
  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT_CYCLES);

  logic [11:0] s1;
  logic [11:0] s2;
  logic [11:0] s3;
  logic [3:0]  hold_cnt;
  logic        hold_done;
  logic        accept;

  logic [3:0]  acc_an;
  logic [2:0]  acc_zeros;
  digit_idx_t  acc_idx;
  logic        dec_valid;
  logic        dec_blank;
  logic [3:0]  dec_bcd;
  logic        acc_digit;
  logic        acc_bad;
  logic        acc_multi;
  logic        stage_wr;

  scan_state_t state;
  logic [3:0]  seen_mask;
  logic [15:0] stage_bcd;
  logic [3:0]  stage_blk;
  logic [3:0]  seen_next;
  logic [15:0] merged_bcd;
  logic [3:0]  merged_blk;
  logic        frame_complete;

  logic [15:0] idle_cnt;
  logic        timeout;

  // Two-flop synchronizer on the whole bus plus a history stage for compare.
  always_ff @(posedge segment_clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {an, seg};
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Counts consecutive identical samples; hold_done blocks re-accepting the
  // same run (also needed when the count saturates at 15). It starts set so
  // the cleared sync registers are never mistaken for a real pattern.
  always_ff @(posedge segment_clk) begin
    if (reset) begin
      hold_cnt  <= 4'd0;
      hold_done <= 1'b1;
    end else if (s2 != s3) begin
      hold_cnt  <= 4'd1;
      hold_done <= 1'b0;
    end else begin
      if (hold_cnt != 4'd15) hold_cnt <= hold_cnt + 4'd1;
      if (accept) hold_done <= 1'b1;
    end
  end

  assign accept = (hold_cnt == STABLE_L) && !hold_done;
  assign acc_an = s3[11:8];

  seg7_to_bcd u_seg7_to_bcd (
    .code  (s3[6:0]),
    .valid (dec_valid),
    .blank (dec_blank),
    .bcd   (dec_bcd)
  );

  // Classify the accepted anode pattern: zero count and driven digit index.
  always_comb begin
    acc_zeros = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!acc_an[i]) acc_zeros = acc_zeros + 3'd1;
    end
    case (acc_an)
      4'b1110: acc_idx = 2'd0;
      4'b1101: acc_idx = 2'd1;
      4'b1011: acc_idx = 2'd2;
      4'b0111: acc_idx = 2'd3;
      default: acc_idx = 2'd0;
    endcase
  end

  assign acc_digit = accept && (acc_zeros == 3'd1);
  assign acc_multi = accept && (acc_zeros >= 3'd2);
  assign stage_wr  = acc_digit && dec_valid;
  assign acc_bad   = acc_digit && !dec_valid;

  // Staging contents as they will be after the current write, so a frame
  // can complete on the same edge that stages its last digit.
  always_comb begin
    merged_bcd = stage_bcd;
    merged_blk = stage_blk;
    seen_next  = seen_mask;
    if (stage_wr) begin
      merged_bcd[{acc_idx, 2'b00} +: 4] = dec_bcd;
      merged_blk[acc_idx]               = dec_blank;
      seen_next[acc_idx]                = 1'b1;
    end
  end

  assign frame_complete = stage_wr && (seen_next == 4'b1111);

  // Cycles since the last one-hot anode accept (bad codes included).
  always_ff @(posedge segment_clk) begin
    if (reset) begin
      idle_cnt <= 16'd0;
    end else if (acc_digit) begin
      idle_cnt <= 16'd0;
    end else if (idle_cnt != 16'hFFFF) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout = (idle_cnt >= TIMEOUT_L);

  // Frame-assembly FSM with registered frame, status and pulse outputs.
  always_ff @(posedge segment_clk) begin
    if (reset) begin
      state       <= IDLE;
      seen_mask   <= 4'd0;
      stage_bcd   <= 16'd0;
      stage_blk   <= 4'd0;
      digits      <= 16'd0;
      blank       <= 4'd0;
      frame_done  <= 1'b0;
      stale       <= 1'b0;
      bad_pattern <= 1'b0;
      an_error    <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      bad_pattern <= acc_bad;
      an_error    <= acc_multi;
      if (stage_wr) begin
        stage_bcd <= merged_bcd;
        stage_blk <= merged_blk;
        seen_mask <= seen_next;
      end
      case (state)
        IDLE: begin
          if (stage_wr) begin
            state <= COLLECT;
          end else if (timeout) begin
            state     <= STALE;
            stale     <= 1'b1;
            seen_mask <= 4'd0;
          end
        end
        COLLECT: begin
          if (frame_complete) begin
            digits     <= merged_bcd;
            blank      <= merged_blk;
            frame_done <= 1'b1;
            seen_mask  <= 4'd0;
          end else if (!stage_wr && timeout) begin
            state     <= STALE;
            stale     <= 1'b1;
            seen_mask <= 4'd0;
          end
        end
        STALE: begin
          if (stage_wr) begin
            state <= COLLECT;
            stale <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          seen_mask <= 4'd0;
        end
      endcase
    end
  end

  // Convert the frame just published; frames with any blank digit are skipped.
  always_ff @(posedge segment_clk) begin
    if (reset) begin
      value_sec    <= 13'd0;
      value_strobe <= 1'b0;
    end else begin
      value_strobe <= frame_done && (blank == 4'd0);
      if (frame_done && (blank == 4'd0)) begin
        value_sec <= frame_to_seconds(digits);
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
module tb_sevenseg_scan_decoder;

  localparam int STABLE = 2;

  logic        segment_clk;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [15:0] digits;
  logic [3:0]  blank;
  logic        frame_done;
  logic [12:0] value_sec;
  logic        value_strobe;
  logic        stale;
  logic        bad_pattern;
  logic        an_error;

  sevenseg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(4096)) dut (
    .segment_clk  (segment_clk),
    .reset        (reset),
    .an           (an),
    .seg          (seg),
    .digits       (digits),
    .blank        (blank),
    .frame_done   (frame_done),
    .value_sec    (value_sec),
    .value_strobe (value_strobe),
    .stale        (stale),
    .bad_pattern  (bad_pattern),
    .an_error     (an_error)
  );

  initial segment_clk = 1'b0;
  always #5 segment_clk = ~segment_clk;

  int total = 0;
  int bad   = 0;

  // codes[0..9] are digits, codes[10] is the all-off pattern
  logic [6:0] codes [11];

  // ---------------- monitor ----------------
  int          fd_cnt = 0;
  int          vs_cnt = 0;
  int          bp_cnt = 0;
  int          ae_cnt = 0;
  logic [19:0] dut_frames [$];
  logic [12:0] dut_vals [$];
  logic        prev_fd = 1'b0;
  logic [3:0]  prev_blank = 4'd0;

  always @(negedge segment_clk) begin
    if (frame_done) begin
      fd_cnt++;
      dut_frames.push_back({blank, digits});
    end
    if (value_strobe) begin
      vs_cnt++;
      dut_vals.push_back(value_sec);
    end
    if (bad_pattern) bp_cnt++;
    if (an_error) ae_cnt++;
    if (value_strobe || (prev_fd && prev_blank == 4'd0)) begin
      total++;
      if (value_strobe !== (prev_fd && prev_blank == 4'd0)) begin
        bad++;
        $display("FAIL strobe_timing: value_strobe=%0b required=%0b", value_strobe,
                 prev_fd && prev_blank == 4'd0);
      end
    end
    prev_fd    = frame_done;
    prev_blank = blank;
  end

  // ---------------- reference model ----------------
  logic [11:0] run_val;
  int          run_len;
  bit          run_acc;
  logic [3:0]  m_stage [4];
  bit   [3:0]  m_sblank;
  bit   [3:0]  m_seen;
  int          exp_bad;
  int          exp_anerr;
  logic [19:0] exp_frames [$];
  logic [12:0] exp_vals [$];

  function automatic int seg_lookup(input logic [6:0] c);
    for (int k = 0; k < 11; k++) if (codes[k] == c) return k;
    return -1;
  endfunction

  function automatic int zeros_of(input logic [3:0] a);
    int z = 0;
    for (int k = 0; k < 4; k++) if (!a[k]) z++;
    return z;
  endfunction

  task automatic model_reset();
    run_val  = 12'h000;
    run_len  = 0;
    run_acc  = 1;
    m_seen   = 4'd0;
    m_sblank = 4'd0;
    for (int k = 0; k < 4; k++) m_stage[k] = 4'd0;
  endtask

  task automatic model_accept(input logic [11:0] v);
    int nz;
    int pos;
    int kd;
    logic [15:0] dg;
    nz = zeros_of(v[11:8]);
    if (nz == 0) return;
    if (nz >= 2) begin
      exp_anerr++;
      return;
    end
    pos = 0;
    for (int k = 0; k < 4; k++) if (!v[8+k]) pos = k;
    kd = seg_lookup(v[6:0]);
    if (kd < 0) begin
      exp_bad++;
      return;
    end
    m_stage[pos]  = (kd == 10) ? 4'd0 : 4'(kd);
    m_sblank[pos] = (kd == 10);
    m_seen[pos]   = 1'b1;
    if (m_seen == 4'b1111) begin
      dg = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
      exp_frames.push_back({4'(m_sblank), dg});
      if (m_sblank == 4'd0)
        exp_vals.push_back(13'((int'(m_stage[3]) * 10 + int'(m_stage[2])) * 60
                               + int'(m_stage[1]) * 10 + int'(m_stage[0])));
      m_seen = 4'd0;
    end
  endtask

  // A value is accepted once its uninterrupted run reaches STABLE cycles.
  task automatic model_step(input logic [11:0] v, input int n);
    if (v == run_val) run_len += n;
    else begin
      run_val = v;
      run_len = n;
      run_acc = 0;
    end
    if (!run_acc && run_len >= STABLE) begin
      run_acc = 1;
      model_accept(v);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an  = a;
    seg = s;
    model_step({a, s}, n);
    repeat (n) @(negedge segment_clk);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 8'hFF, n);
  endtask

  task automatic scan_frame(input logic [6:0] c3, input logic [6:0] c2,
                            input logic [6:0] c1, input logic [6:0] c0, input int h);
    drive(4'b1110, {1'b1, c0}, h);
    drive(4'b1101, {1'b1, c1}, h);
    drive(4'b1011, {1'b1, c2}, h);
    drive(4'b0111, {1'b1, c3}, h);
  endtask

  task automatic do_reset();
    an    = 4'hF;
    seg   = 8'hFF;
    reset = 1'b1;
    repeat (2) @(negedge segment_clk);
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [6:0]  c3, c2, c1, c0;
    logic [15:0] exp_digits;
    logic [3:0]  exp_blank;
    logic        exp_strobe;
    logic [12:0] exp_value;
  } frame_vec_t;

  frame_vec_t vecs [8];

  initial begin
    int fd0, vs0, bp0, ae0;
    logic [15:0] mask;
    int ptr;

    codes[0] = 7'h40; codes[1] = 7'h79; codes[2] = 7'h24; codes[3] = 7'h30;
    codes[4] = 7'h19; codes[5] = 7'h12; codes[6] = 7'h02; codes[7] = 7'h78;
    codes[8] = 7'h00; codes[9] = 7'h10; codes[10] = 7'h7F;

    vecs[0] = '{7'h79, 7'h24, 7'h30, 7'h19, 16'h1234, 4'b0000, 1'b1, 13'd754};
    vecs[1] = '{7'h10, 7'h10, 7'h12, 7'h10, 16'h9959, 4'b0000, 1'b1, 13'd5999};
    vecs[2] = '{7'h40, 7'h40, 7'h40, 7'h40, 16'h0000, 4'b0000, 1'b1, 13'd0};
    vecs[3] = '{7'h7F, 7'h24, 7'h30, 7'h19, 16'h0234, 4'b1000, 1'b0, 13'd0};
    vecs[4] = '{7'h10, 7'h10, 7'h10, 7'h10, 16'h9999, 4'b0000, 1'b1, 13'd6039};
    vecs[5] = '{7'h40, 7'h10, 7'h10, 7'h10, 16'h0999, 4'b0000, 1'b1, 13'd639};
    vecs[6] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 16'h0000, 4'b1111, 1'b0, 13'd639};
    vecs[7] = '{7'h12, 7'h10, 7'h40, 7'h78, 16'h5907, 4'b0000, 1'b1, 13'd3547};

    exp_bad   = 0;
    exp_anerr = 0;
    an    = 4'hF;
    seg   = 8'hFF;
    reset = 1'b1;
    repeat (3) @(negedge segment_clk);
    reset = 1'b0;
    model_reset();

    check("reset_outputs", 32'({digits, blank, value_sec, frame_done, value_strobe,
                                stale, bad_pattern, an_error}), 32'd0);
    idle(6);

    // table-driven frames
    for (int v = 0; v < 8; v++) begin
      fd0 = fd_cnt;
      vs0 = vs_cnt;
      scan_frame(vecs[v].c3, vecs[v].c2, vecs[v].c1, vecs[v].c0, 4);
      idle(10);
      mask = 16'hFFFF;
      for (int k = 0; k < 4; k++) if (vecs[v].exp_blank[k]) mask[4*k +: 4] = 4'h0;
      check($sformatf("vec%0d_frame_done", v), 32'(fd_cnt - fd0), 32'd1);
      check($sformatf("vec%0d_digits", v), 32'(digits & mask), 32'(vecs[v].exp_digits & mask));
      check($sformatf("vec%0d_blank", v), 32'(blank), 32'(vecs[v].exp_blank));
      check($sformatf("vec%0d_strobes", v), 32'(vs_cnt - vs0), 32'(vecs[v].exp_strobe));
      check($sformatf("vec%0d_value", v), 32'(value_sec), 32'(vecs[v].exp_value));
    end

    // one-cycle digit is rejected, two cycles accepted once
    fd0 = fd_cnt;
    drive(4'b1110, 8'h99, 4);
    drive(4'b1101, 8'hB0, 4);
    drive(4'b1011, 8'hA4, 4);
    drive(4'b0111, 8'hF9, 1);
    idle(10);
    check("glitch_no_frame", 32'(fd_cnt - fd0), 32'd0);
    drive(4'b0111, 8'hF9, 2);
    idle(10);
    check("hold2_frame", 32'(fd_cnt - fd0), 32'd1);
    check("hold2_digits", 32'(digits), 32'h1234);

    // unknown code: pulse, digit not staged
    fd0 = fd_cnt;
    bp0 = bp_cnt;
    drive(4'b1110, 8'hAA, 4);
    idle(6);
    check("bad_pattern_pulse", 32'(bp_cnt - bp0), 32'd1);
    drive(4'b1101, 8'hB0, 4);
    drive(4'b1011, 8'hA4, 4);
    drive(4'b0111, 8'hF9, 4);
    idle(10);
    check("bad_not_staged", 32'(fd_cnt - fd0), 32'd0);
    drive(4'b1110, 8'h99, 4);
    idle(10);
    check("after_bad_frame", 32'(fd_cnt - fd0), 32'd1);
    check("after_bad_digits", 32'(digits), 32'h1234);

    // two anodes low
    fd0 = fd_cnt;
    bp0 = bp_cnt;
    ae0 = ae_cnt;
    drive(4'b1100, 8'h90, 4);
    idle(6);
    check("an_error_pulse", 32'(ae_cnt - ae0), 32'd1);
    check("an_error_no_bad", 32'(bp_cnt - bp0), 32'd0);
    check("an_error_no_frame", 32'(fd_cnt - fd0), 32'd0);

    // stale timeout and recovery
    idle(4000);
    check("stale_early", 32'(stale), 32'd0);
    idle(110);
    check("stale_set", 32'(stale), 32'd1);
    fd0 = fd_cnt;
    drive(4'b1110, 8'h99, 4);
    idle(4);
    check("stale_cleared", 32'(stale), 32'd0);
    drive(4'b1101, 8'hB0, 4);
    drive(4'b1011, 8'hA4, 4);
    drive(4'b0111, 8'hF9, 4);
    idle(10);
    check("stale_recover_frame", 32'(fd_cnt - fd0), 32'd1);

    // reset mid-frame discards staging
    drive(4'b1110, 8'h99, 4);
    drive(4'b1101, 8'hB0, 4);
    do_reset();
    check("midreset_outputs", 32'({digits, blank, value_sec, frame_done, value_strobe,
                                   stale, bad_pattern, an_error}), 32'd0);
    fd0 = fd_cnt;
    vs0 = vs_cnt;
    drive(4'b1011, 8'hA4, 4);
    drive(4'b0111, 8'hF9, 4);
    idle(10);
    check("midreset_no_frame", 32'(fd_cnt - fd0), 32'd0);
    check("midreset_digits", 32'(digits), 32'd0);
    scan_frame(7'h79, 7'h24, 7'h30, 7'h19, 3);
    idle(10);
    check("postreset_frame", 32'(fd_cnt - fd0), 32'd1);
    check("postreset_value", 32'(value_sec), 32'd754);
    check("postreset_strobe", 32'(vs_cnt - vs0), 32'd1);

    // randomized scan against the model
    do_reset();
    idle(6);
    dut_frames.delete();
    dut_vals.delete();
    exp_frames.delete();
    exp_vals.delete();
    exp_bad   = 0;
    exp_anerr = 0;
    bp0 = bp_cnt;
    ae0 = ae_cnt;
    ptr = 0;
    for (int n = 0; n < 600; n++) begin
      int r;
      int h;
      logic [3:0] a;
      logic [7:0] s;
      r = int'($urandom_range(0, 99));
      h = int'($urandom_range(1, 5));
      s[7] = 1'($urandom_range(0, 1));
      if (r < 75) begin
        ptr = (r < 65) ? (ptr + 1) % 4 : int'($urandom_range(0, 3));
        a = ~(4'b0001 << ptr);
        s[6:0] = codes[$urandom_range(0, 10)];
      end else if (r < 83) begin
        a = 4'hF;
        s[6:0] = 7'h7F;
      end else if (r < 91) begin
        a = ~(4'b0001 << $urandom_range(0, 3));
        s[6:0] = 7'($urandom);
        while (seg_lookup(s[6:0]) >= 0) s[6:0] = 7'($urandom);
      end else begin
        a = 4'($urandom);
        while (zeros_of(a) < 2) a = 4'($urandom);
        s[6:0] = codes[$urandom_range(0, 10)];
      end
      drive(a, s, h);
    end
    idle(12);

    check("rand_frame_count", 32'(dut_frames.size()), 32'(exp_frames.size()));
    for (int k = 0; k < exp_frames.size() && k < dut_frames.size(); k++)
      check($sformatf("rand_frame%0d", k), 32'(dut_frames[k]), 32'(exp_frames[k]));
    check("rand_value_count", 32'(dut_vals.size()), 32'(exp_vals.size()));
    for (int k = 0; k < exp_vals.size() && k < dut_vals.size(); k++)
      check($sformatf("rand_value%0d", k), 32'(dut_vals[k]), 32'(exp_vals[k]));
    check("rand_bad_pattern", 32'(bp_cnt - bp0), 32'(exp_bad));
    check("rand_an_error", 32'(ae_cnt - ae0), 32'(exp_anerr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
